otbn_pq_ntt_seq: RTL and testbench

//  Sequencer for the OTBN PQ butterfly datapath (CTBF/GSBF instructions).
//  On start, walks all NTT layers and issues one butterfly request per cycle:

---
 rtl/otbn_pkg.sv | 15 +
 rtl/otbn_pq_ntt_seq.sv | 163 ++++++++++++++++
 tb/tb_otbn_pq_ntt_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/otbn_pkg.sv
// OTBN shared types: PQ butterfly operation and NTT sequencer state encodings.
package otbn_pkg;

    typedef enum logic {
        PqBfCt,
        PqBfGs
    } pq_bf_op_e;

    typedef enum logic [1:0] {
        PqNttSeqIdle,
        PqNttSeqRun,
        PqNttSeqDone
    } pq_ntt_seq_state_e;

endpackage

// File: rtl/otbn_pq_ntt_seq.sv
// NTT sequencer: walks every layer and issues one CT/GS butterfly request per cycle.
// Inverse (GS) sequencing is built only when OTBN_PQ_NTT_INV_EN is defined.
module otbn_pq_ntt_seq
    import otbn_pkg::*;
#(
    parameter int unsigned LogN      = 8,
    parameter int unsigned NumLayers = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      inv_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      bf_valid_o,
    input  logic                      bf_ready_i,
    output pq_bf_op_e                 bf_op_o,
    output logic [LogN-1:0]           bf_idx_a_o,
    output logic [LogN-1:0]           bf_idx_b_o,
    output logic [LogN-1:0]           bf_tw_idx_o,
    output logic [$clog2(LogN+1)-1:0] bf_layer_o
);

    localparam int unsigned CntW   = LogN + 1;
    localparam int unsigned LayerW = $clog2(LogN + 1);

    localparam logic [CntW-1:0] NCoef       = CntW'(1) << LogN;
    localparam logic [CntW-1:0] LenFirstFwd = NCoef >> 1;
    localparam logic [CntW-1:0] LenFirstInv = NCoef >> NumLayers;
    localparam logic [CntW-1:0] KFirstInv   = (CntW'(1) << NumLayers) - CntW'(1);
    localparam logic [LayerW-1:0] LastLayer = LayerW'(NumLayers - 1);

    pq_ntt_seq_state_e r_state, w_state_next;

    logic [CntW-1:0]   r_j, r_len, r_k;
    logic [LayerW-1:0] r_layer;

    logic              w_fire, w_blk_end, w_layer_end, w_last;
    logic [CntW-1:0]   w_j_blk_next;
    logic [CntW-1:0]   w_len_init, w_k_init, w_len_step, w_k_step;
    logic [LogN-1:0]   w_idx_b;
    pq_bf_op_e         w_op;

    assign w_fire       = (r_state == PqNttSeqRun) && bf_ready_i;
    // Blocks are 2*len aligned, so the low bits of j mark the last butterfly of a block.
    assign w_blk_end    = ((r_j & (r_len - CntW'(1))) == (r_len - CntW'(1)));
    assign w_j_blk_next = r_j + r_len + CntW'(1);
    assign w_layer_end  = w_blk_end && (w_j_blk_next == NCoef);
    assign w_last       = w_layer_end && (r_layer == LastLayer);
    assign w_idx_b      = LogN'(r_j + r_len);

`ifdef OTBN_PQ_NTT_INV_EN
    logic r_inv;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_inv <= 1'b0;
        end else if (r_state == PqNttSeqIdle && start_i) begin
            r_inv <= inv_i;
        end
    end

    assign w_len_init = inv_i ? LenFirstInv : LenFirstFwd;
    assign w_k_init   = inv_i ? KFirstInv : CntW'(1);
    assign w_len_step = r_inv ? (r_len << 1) : (r_len >> 1);
    assign w_k_step   = r_inv ? (r_k - CntW'(1)) : (r_k + CntW'(1));
    assign w_op       = r_inv ? PqBfGs : PqBfCt;
`else
    logic w_unused_inv;
    logic [CntW-1:0] w_unused_inv_cfg;

    assign w_unused_inv     = inv_i;
    assign w_unused_inv_cfg = LenFirstInv ^ KFirstInv;
    assign w_len_init       = LenFirstFwd;
    assign w_k_init         = CntW'(1);
    assign w_len_step       = r_len >> 1;
    assign w_k_step         = r_k + CntW'(1);
    assign w_op             = PqBfCt;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= PqNttSeqIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            PqNttSeqIdle: if (start_i) w_state_next = PqNttSeqRun;
            PqNttSeqRun:  if (w_fire && w_last) w_state_next = PqNttSeqDone;
            PqNttSeqDone: w_state_next = PqNttSeqIdle;
            default:      w_state_next = PqNttSeqIdle;
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        bf_valid_o  = 1'b0;
        bf_op_o     = PqBfCt;
        bf_idx_a_o  = '0;
        bf_idx_b_o  = '0;
        bf_tw_idx_o = '0;
        bf_layer_o  = '0;
        unique case (r_state)
            PqNttSeqRun: begin
                busy_o      = 1'b1;
                bf_valid_o  = 1'b1;
                bf_op_o     = w_op;
                bf_idx_a_o  = r_j[LogN-1:0];
                bf_idx_b_o  = w_idx_b;
                bf_tw_idx_o = r_k[LogN-1:0];
                bf_layer_o  = r_layer;
            end
            PqNttSeqDone: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_j     <= '0;
            r_len   <= '0;
            r_k     <= '0;
            r_layer <= '0;
        end else begin
            unique case (r_state)
                PqNttSeqIdle: begin
                    if (start_i) begin
                        r_j     <= '0;
                        r_layer <= '0;
                        r_len   <= w_len_init;
                        r_k     <= w_k_init;
                    end
                end
                PqNttSeqRun: begin
                    if (w_fire) begin
                        if (!w_blk_end) begin
                            r_j <= r_j + CntW'(1);
                        end else begin
                            r_j <= w_layer_end ? '0 : w_j_blk_next;
                            r_k <= w_k_step;
                            if (w_layer_end) begin
                                r_len   <= w_len_step;
                                r_layer <= r_layer + LayerW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_j     <= '0;
                    r_len   <= '0;
                    r_k     <= '0;
                    r_layer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otbn_pq_ntt_seq.sv
// Self-checking bench for otbn_pq_ntt_seq: randomized backpressure and stray starts
// checked against a loop-nest reference of the NTT butterfly schedule.
module tb_otbn_pq_ntt_seq;
    import otbn_pkg::*;

    localparam int LogN   = 8;
    localparam int NCoef  = 256;
    localparam int LayerW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start1, inv, ready;

    logic              busy0, done0, valid0, busy1, done1, valid1;
    pq_bf_op_e         op0, op1;
    logic [LogN-1:0]   a0, b0, tw0, a1, b1, tw1;
    logic [LayerW-1:0] ly0, ly1;

    otbn_pq_ntt_seq #(.LogN(8), .NumLayers(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .inv_i(inv),
        .busy_o(busy0), .done_o(done0), .bf_valid_o(valid0), .bf_ready_i(ready),
        .bf_op_o(op0), .bf_idx_a_o(a0), .bf_idx_b_o(b0), .bf_tw_idx_o(tw0),
        .bf_layer_o(ly0)
    );

    otbn_pq_ntt_seq #(.LogN(8), .NumLayers(7)) u_dut7 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .inv_i(inv),
        .busy_o(busy1), .done_o(done1), .bf_valid_o(valid1), .bf_ready_i(ready),
        .bf_op_o(op1), .bf_idx_a_o(a1), .bf_idx_b_o(b1), .bf_tw_idx_o(tw1),
        .bf_layer_o(ly1)
    );

    int sel;
    logic t_busy, t_done, t_valid;
    int   t_a, t_b, t_tw, t_layer, t_op;

    always_comb begin
        t_busy  = (sel == 1) ? busy1  : busy0;
        t_done  = (sel == 1) ? done1  : done0;
        t_valid = (sel == 1) ? valid1 : valid0;
        t_a     = (sel == 1) ? int'(a1)  : int'(a0);
        t_b     = (sel == 1) ? int'(b1)  : int'(b0);
        t_tw    = (sel == 1) ? int'(tw1) : int'(tw0);
        t_layer = (sel == 1) ? int'(ly1) : int'(ly0);
        t_op    = (sel == 1) ? int'(op1) : int'(op0);
    end

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int a;
        int b;
        int tw;
        int layer;
        int op;
    } bf_t;

    bf_t exp_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Textbook NTT loop nest: one entry per butterfly in issue order.
    function automatic void build_model(input int nl, input bit inv_m);
        int k;
        int len;
        bf_t e;
        exp_q.delete();
        k = inv_m ? ((1 << nl) - 1) : 1;
        for (int l = 0; l < nl; l++) begin
            len = inv_m ? ((NCoef >> nl) << l) : (NCoef >> (l + 1));
            for (int s = 0; s < NCoef; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    e.a = j; e.b = j + len; e.tw = k; e.layer = l; e.op = int'(inv_m);
                    exp_q.push_back(e);
                end
                k = inv_m ? k - 1 : k + 1;
            end
        end
    endfunction

    task automatic drive_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start0 = v;
    endtask

    task automatic run_xform(input int s, input bit inv_req, input int nl, input int bp_pct,
                             input bit stray, input int stall_at, input int stall_len,
                             input int abort_at);
        int  cyc, fires, stalls, stall_left, total;
        bit  inv_eff, stall_done;
        bf_t e;
`ifdef OTBN_PQ_NTT_INV_EN
        inv_eff = inv_req;
`else
        inv_eff = 1'b0;
`endif
        build_model(nl, inv_eff);
        total = exp_q.size();
        sel = s; cyc = 0; fires = 0; stalls = 0; stall_left = 0; stall_done = 0;
        inv = inv_req;
        ready = 1'b1;
        drive_start(s, 1'b1);
        @(posedge clk); #1;
        cyc = 1;
        drive_start(s, 1'b0);
        inv = 1'($urandom_range(1));
        while (!t_done && cyc < 6000 && exp_q.size() > 0) begin
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else if (!stall_done && stall_at > 0 && fires == stall_at - 1) begin
                ready = 1'b0;
                stall_left = stall_len - 1;
                stall_done = 1'b1;
            end else begin
                ready = ($urandom_range(99) >= bp_pct);
            end
            drive_start(s, stray && ($urandom_range(15) == 0));
            inv = 1'($urandom_range(1));
            e = exp_q[0];
            check_eq("valid", int'(t_valid), 1);
            check_eq("busy", int'(t_busy), 1);
            check_eq("idx_a", t_a, e.a);
            check_eq("idx_b", t_b, e.b);
            check_eq("tw_idx", t_tw, e.tw);
            check_eq("layer", t_layer, e.layer);
            check_eq("op", t_op, e.op);
            if (ready) begin
                void'(exp_q.pop_front());
                fires++;
                if (fires == abort_at) rst_n = 1'b0;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                check_eq("abort_busy", int'(t_busy), 0);
                check_eq("abort_valid", int'(t_valid), 0);
                check_eq("abort_done", int'(t_done), 0);
                rst_n = 1'b1;
                drive_start(s, 1'b0);
                @(posedge clk); #1;
                check_eq("abort_idle_done", int'(t_done), 0);
                return;
            end
        end
        drive_start(s, 1'b0);
        check_eq("done_seen", int'(t_done), 1);
        check_eq("fire_count", fires, total);
        check_eq("cycles", cyc, total + stalls + 1);
        check_eq("done_valid", int'(t_valid), 0);
        check_eq("done_busy", int'(t_busy), 0);
        if (stray) drive_start(s, 1'b1);
        ready = 1'($urandom_range(1));
        @(posedge clk); #1;
        drive_start(s, 1'b0);
        check_eq("idle_done", int'(t_done), 0);
        check_eq("idle_busy", int'(t_busy), 0);
        check_eq("idle_valid", int'(t_valid), 0);
        @(posedge clk); #1;
        check_eq("idle_busy2", int'(t_busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sel = 0; rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; inv = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        start0 = 1'b1; start1 = 1'b1; inv = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            check_eq("rst_busy", int'(t_busy), 0);
            check_eq("rst_done", int'(t_done), 0);
            check_eq("rst_valid", int'(t_valid), 0);
            check_eq("rst_a", t_a, 0);
            check_eq("rst_b", t_b, 0);
            check_eq("rst_tw", t_tw, 0);
            check_eq("rst_layer", t_layer, 0);
            check_eq("rst_op", t_op, 0);
        end
        start0 = 1'b0; start1 = 1'b0; inv = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_xform(0, 1'b0, 8, 0, 1'b0, 0, 0, 0);
        run_xform(0, 1'b1, 8, 0, 1'b0, 0, 0, 0);
        run_xform(1, 1'b0, 7, 0, 1'b0, 0, 0, 0);
        run_xform(0, 1'b0, 8, 0, 1'b0, 10, 5, 0);
        run_xform(0, 1'b0, 8, 0, 1'b0, 0, 0, 300);
        run_xform(0, 1'b0, 8, 0, 1'b0, 0, 0, 0);
        run_xform(0, 1'b0, 8, 0, 1'b1, 0, 0, 0);
        run_xform(0, 1'($urandom_range(1)), 8, 30, 1'b1, 0, 0, 0);
        run_xform(1, 1'($urandom_range(1)), 7, 40, 1'b1, 0, 0, 0);
        run_xform(1, 1'b1, 7, 20, 1'b0, 37, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
